// File: rtl/register_file.sv
// Parametrised register bank: one write port, two registered read ports with
// write-first bypass, optional hardwired-zero entry 0 and dropped-write flag.
module register_file #(
    parameter int unsigned          DATA_WIDTH  = 8,
    parameter int unsigned          DEPTH       = 8,
    parameter int unsigned          ADDR_WIDTH  = $clog2(DEPTH),
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter bit                   ZERO_REG    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    input  logic                  rd_en_b,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    output logic                  wr_err
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  wr_accept;
    logic [DATA_WIDTH-1:0] rd_next_a;
    logic [DATA_WIDTH-1:0] rd_next_b;

    // True for addresses that map to real, writable storage.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return (32'(a) < DEPTH) && !(ZERO_REG && (a == '0));
    endfunction

    always_comb begin
        wr_accept = wr_en && addr_ok(wr_addr);
    end

    always_comb begin
        rd_next_a = '0;
        if (addr_ok(rd_addr_a)) begin
            if (wr_accept && (wr_addr == rd_addr_a)) rd_next_a = wr_data;
            else                                     rd_next_a = mem[rd_addr_a];
        end
    end

    always_comb begin
        rd_next_b = '0;
        if (addr_ok(rd_addr_b)) begin
            if (wr_accept && (wr_addr == rd_addr_b)) rd_next_b = wr_data;
            else                                     rd_next_b = mem[rd_addr_b];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[ADDR_WIDTH'(i)] <= (ZERO_REG && (i == 0)) ? '0 : RESET_VALUE;
            end
            rd_data_a <= '0;
            rd_data_b <= '0;
            wr_err    <= 1'b0;
        end else begin
            if (wr_accept) mem[wr_addr] <= wr_data;
            if (rd_en_a)   rd_data_a    <= rd_next_a;
            if (rd_en_b)   rd_data_b    <= rd_next_b;
            if (wr_en)     wr_err       <= !wr_accept;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: two instances (8 entries / 5 entries with
// zero register) driven in lockstep and checked against an array-based model.
module tb_register_file;

    typedef struct packed {
        logic       rst;
        logic       we;
        logic [2:0] wa;
        logic [7:0] wd;
        logic       rea;
        logic [2:0] raa;
        logic       reb;
        logic [2:0] rab;
    } op_t;

    typedef struct packed {
        logic [1:0][7:0] a;
        logic [1:0][7:0] b;
        logic [1:0]      e;
        logic [31:0]     cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    op_t        op0, op1;
    logic [7:0] rda0, rdb0, rda1, rdb1;
    logic       err0, err1;

    register_file #(.DATA_WIDTH(8), .DEPTH(8), .RESET_VALUE(8'h5A), .ZERO_REG(1'b0)) dut0 (
        .clk(clk), .rst(op0.rst), .wr_en(op0.we), .wr_addr(op0.wa), .wr_data(op0.wd),
        .rd_en_a(op0.rea), .rd_addr_a(op0.raa), .rd_data_a(rda0),
        .rd_en_b(op0.reb), .rd_addr_b(op0.rab), .rd_data_b(rdb0), .wr_err(err0)
    );

    register_file #(.DATA_WIDTH(8), .DEPTH(5), .RESET_VALUE(8'h3C), .ZERO_REG(1'b1)) dut1 (
        .clk(clk), .rst(op1.rst), .wr_en(op1.we), .wr_addr(op1.wa), .wr_data(op1.wd),
        .rd_en_a(op1.rea), .rd_addr_a(op1.raa), .rd_data_a(rda1),
        .rd_en_b(op1.reb), .rd_addr_b(op1.rab), .rd_data_b(rdb1), .wr_err(err1)
    );

    // Reference model state
    int         depth_c [2] = '{8, 5};
    bit         zr_c    [2] = '{1'b0, 1'b1};
    logic [7:0] rv_c    [2] = '{8'h5A, 8'h3C};
    logic [7:0] mm [2][8];
    logic [7:0] ma [2];
    logic [7:0] mb [2];
    logic       me [2];

    exp_t q[$];
    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;

    function automatic op_t mk(input logic r, input logic we, input int wa, input int wd,
                               input logic rea, input int raa, input logic reb, input int rab);
        op_t o;
        o.rst = r;     o.we  = we;    o.wa  = 3'(wa);  o.wd = 8'(wd);
        o.rea = rea;   o.raa = 3'(raa); o.reb = reb;  o.rab = 3'(rab);
        return o;
    endfunction

    function automatic logic [7:0] peek(input int d, input logic [2:0] a, input bit acc, input op_t o);
        if (int'(a) >= depth_c[d] || (zr_c[d] && a == 3'd0)) return 8'h00;
        if (acc && o.wa == a) return o.wd;
        return mm[d][a];
    endfunction

    task automatic model(input int d, input op_t o);
        bit acc;
        if (o.rst) begin
            for (int k = 0; k < 8; k++) mm[d][k] = (zr_c[d] && k == 0) ? 8'h00 : rv_c[d];
            ma[d] = 8'h00;
            mb[d] = 8'h00;
            me[d] = 1'b0;
        end else begin
            acc = o.we && (int'(o.wa) < depth_c[d]) && !(zr_c[d] && o.wa == 3'd0);
            if (o.rea) ma[d] = peek(d, o.raa, acc, o);
            if (o.reb) mb[d] = peek(d, o.rab, acc, o);
            if (o.we)  me[d] = !acc;
            if (acc)   mm[d][o.wa] = o.wd;
        end
    endtask

    task automatic step(input op_t o0, input op_t o1);
        exp_t x;
        @(negedge clk);
        op0 = o0;
        op1 = o1;
        @(posedge clk);
        model(0, o0);
        model(1, o1);
        for (int d = 0; d < 2; d++) begin
            x.a[d] = ma[d];
            x.b[d] = mb[d];
            x.e[d] = me[d];
        end
        x.cyc = 32'(cyc);
        q.push_back(x);
        cyc++;
    endtask

    function automatic void chk(input string name, input int c, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, c, got, want);
    endfunction

    // Monitor: outputs are registered, so every pushed expectation is visible
    // at the falling edge following the edge it was computed for.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("d0_rd_a", int'(x.cyc), rda0, x.a[0]);
                chk("d0_rd_b", int'(x.cyc), rdb0, x.b[0]);
                chk("d0_wr_err", int'(x.cyc), {7'd0, err0}, {7'd0, x.e[0]});
                chk("d1_rd_a", int'(x.cyc), rda1, x.a[1]);
                chk("d1_rd_b", int'(x.cyc), rdb1, x.b[1]);
                chk("d1_wr_err", int'(x.cyc), {7'd0, err1}, {7'd0, x.e[1]});
            end
        end
    end

    initial begin
        op_t idle, rs, r0, r1;
        idle = '0;
        rs   = mk(1, 0, 0, 0, 0, 0, 0, 0);
        op0  = rs;
        op1  = rs;

        step(rs, rs);
        for (int i = 0; i < 8; i++) step(mk(0, 0, 0, 0, 1, i, 0, 0), idle);

        for (int i = 0; i < 8; i++) step(mk(0, 1, i, 8'h10 + i, 0, 0, 0, 0), idle);
        for (int i = 0; i < 8; i++) step(mk(0, 0, 0, 0, 1, i, 1, 7 - i), idle);

        step(mk(0, 1, 2, 8'hAA, 0, 0, 0, 0), idle);
        step(mk(0, 1, 2, 8'h55, 1, 2, 1, 2), idle);
        step(mk(0, 0, 0, 0, 1, 2, 1, 2), idle);

        step(mk(1, 1, 4, 8'h77, 1, 4, 0, 0), idle);
        step(mk(0, 0, 0, 0, 1, 4, 1, 4), idle);

        step(idle, mk(0, 1, 1, 8'h11, 0, 0, 0, 0));
        step(idle, mk(0, 0, 0, 0, 1, 1, 0, 0));
        for (int i = 0; i < 3; i++) step(idle, mk(0, 0, 0, 0, 0, 3, 0, 0));
        step(idle, mk(0, 1, 6, 8'hC3, 1, 6, 1, 6));
        step(idle, mk(0, 0, 0, 0, 1, 6, 0, 0));
        for (int i = 0; i < 5; i++) step(idle, mk(0, 0, 0, 0, 1, i, 1, 4 - i));
        step(idle, mk(0, 1, 0, 8'hFF, 1, 0, 0, 0));
        step(idle, mk(0, 0, 0, 0, 1, 0, 1, 0));
        step(idle, mk(0, 1, 1, 8'h22, 0, 0, 1, 1));

        for (int n = 0; n < 400; n++) begin
            r0 = op_t'({$urandom, $urandom});
            r1 = op_t'({$urandom, $urandom});
            r0.rst = ($urandom_range(0, 49) == 0);
            r1.rst = ($urandom_range(0, 49) == 0);
            step(r0, r1);
        end

        @(negedge clk);
        op0 = idle;
        op1 = idle;
        repeat (2) @(negedge clk);
        total++;
        if (q.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
